// File: rtl/color_pick_decoder.sv
// rtl/color_pick_decoder.sv - recovers coarse x/y cursor coordinates from the coordinate-encoded pixel colour
// A pick latches the cursor and waits for STABLE frames that agree before reporting.
module color_pick_decoder #(
   parameter int PIXLW    = 12,
   parameter int STABLE   = 3,
   parameter int MAX_MISS = 2,
   parameter int INT_BITS = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_start,
   input  logic                pix_valid,
   input  logic [INT_BITS-1:0] x,
   input  logic [INT_BITS-1:0] y,
   input  logic [PIXLW-1:0]    pix_color,
   input  logic [INT_BITS-1:0] sx,
   input  logic [INT_BITS-1:0] sy,
   input  logic                pick_req,
   output logic                pick_busy,
   output logic                pick_valid,
   input  logic                pick_ready,
   output logic [INT_BITS-1:0] pick_x,
   output logic [INT_BITS-1:0] pick_y,
   output logic                pick_err
);

   localparam int MW = (STABLE > 1) ? $clog2(STABLE + 1) : 1;
   localparam int NW = (MAX_MISS > 1) ? $clog2(MAX_MISS + 1) : 1;
   localparam logic [MW-1:0] STABLE_C = MW'(STABLE);
   localparam logic [NW-1:0] MISS_C   = NW'(MAX_MISS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_SAMPLE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [INT_BITS-1:0]   r_lsx;
   logic [INT_BITS-1:0]   r_lsy;
   logic [PIXLW-1:0]      r_sample;
   logic [PIXLW-1:0]      r_prev;
   logic [MW-1:0]         r_match;
   logic [NW-1:0]         r_miss;
   logic [INT_BITS-1:0]   r_pick_x;
   logic [INT_BITS-1:0]   r_pick_y;
   logic                  r_pick_err;

   logic                  w_hit;
   logic [MW-1:0]         w_match_inc;
   logic [NW-1:0]         w_miss_inc;

   always_comb begin
      w_hit = pix_valid && (x == r_lsx) && (y == r_lsy);

      // First sample of a pick always counts; a disagreeing sample restarts the run at 1.
      if ((r_match == '0) || (r_sample == r_prev)) begin
         w_match_inc = (r_match == STABLE_C) ? r_match : r_match + MW'(1);
      end else begin
         w_match_inc = MW'(1);
      end
      w_miss_inc = (r_miss == MISS_C) ? r_miss : r_miss + NW'(1);

      w_next = r_state;
      case (r_state)
         S_IDLE:   if (pick_req) w_next = S_ARM;
         S_ARM:    if (frame_start) w_next = w_hit ? S_CHECK : S_SAMPLE;
         S_SAMPLE: begin
            if (w_hit) begin
               w_next = S_CHECK;
            end else if (frame_start && (w_miss_inc == MISS_C)) begin
               w_next = S_DONE;
            end
         end
         S_CHECK:  w_next = (w_match_inc == STABLE_C) ? S_DONE : S_ARM;
         S_DONE:   if (pick_ready) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_lsx      <= '0;
         r_lsy      <= '0;
         r_sample   <= '0;
         r_prev     <= '0;
         r_match    <= '0;
         r_miss     <= '0;
         r_pick_x   <= '0;
         r_pick_y   <= '0;
         r_pick_err <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (pick_req) begin
                  r_lsx   <= sx;
                  r_lsy   <= sy;
                  r_match <= '0;
                  r_miss  <= '0;
               end
            end
            S_ARM: begin
               if (frame_start && w_hit) r_sample <= pix_color;
            end
            S_SAMPLE: begin
               if (w_hit) begin
                  r_sample <= pix_color;
               end else if (frame_start) begin
                  r_miss <= w_miss_inc;
                  if (w_miss_inc == MISS_C) begin
                     r_pick_x   <= '0;
                     r_pick_y   <= '0;
                     r_pick_err <= 1'b1;
                  end
               end
            end
            S_CHECK: begin
               r_match <= w_match_inc;
               r_prev  <= r_sample;
               r_miss  <= '0;
               if (w_match_inc == STABLE_C) begin
                  r_pick_x   <= INT_BITS'({r_sample[5:0], 1'b0});
                  r_pick_y   <= INT_BITS'({r_sample[11:6], 1'b0});
                  r_pick_err <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign pick_busy  = (r_state != S_IDLE);
   assign pick_valid = (r_state == S_DONE);
   assign pick_x     = r_pick_x;
   assign pick_y     = r_pick_y;
   assign pick_err   = r_pick_err;

endmodule

// File: tb/tb_color_pick_decoder.sv
// tb/tb_color_pick_decoder.sv - scoreboard bench for color_pick_decoder
// Stimulus pushes expected results; a monitor pops them on each valid/ready handshake.
module tb_color_pick_decoder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        frame_start = 1'b0;
   logic        pix_valid = 1'b0;
   logic [9:0]  x = '0;
   logic [9:0]  y = '0;
   logic [11:0] pix_color = '0;
   logic [9:0]  sx = '0;
   logic [9:0]  sy = '0;
   logic        pick_req = 1'b0;
   logic        pick_busy;
   logic        pick_valid;
   logic        pick_ready = 1'b1;
   logic [9:0]  pick_x;
   logic [9:0]  pick_y;
   logic        pick_err;

   color_pick_decoder #(.PIXLW(12), .STABLE(3), .MAX_MISS(2), .INT_BITS(10)) dut (
      .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
      .x(x), .y(y), .pix_color(pix_color), .sx(sx), .sy(sy), .pick_req(pick_req),
      .pick_busy(pick_busy), .pick_valid(pick_valid), .pick_ready(pick_ready),
      .pick_x(pick_x), .pick_y(pick_y), .pick_err(pick_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [9:0] rx;
      logic [9:0] ry;
      logic       rerr;
   } res_t;

   res_t exp_q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   hit_cyc = 0;
   logic last_valid = 1'b0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (pick_valid === 1'b1 && !last_valid && exp_q.size() > 0 && !exp_q[0].rerr)
         chk("latency", cyc - hit_cyc, 2);
      if (pick_valid === 1'b1 && pick_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            res_t e;
            e = exp_q.pop_front();
            chk("result", {pick_x, pick_y, pick_err}, {e.rx, e.ry, e.rerr});
         end
      end
      last_valid = (pick_valid === 1'b1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pick(input logic [9:0] px, input logic [9:0] py);
      step();
      sx = px; sy = py; pick_req = 1'b1;
      step();
      pick_req = 1'b0;
   endtask

   // One short frame: pixel 0 carries frame_start, pixel 1 or pixel 0 may be the cursor hit.
   task automatic frame(input logic [9:0] cx, input logic [9:0] cy, input logic [11:0] c,
                        input bit present, input bit at_fs);
      step();
      frame_start = 1'b1; pix_valid = 1'b1;
      if (present && at_fs) begin
         x = cx; y = cy; pix_color = c; hit_cyc = cyc;
      end else begin
         x = 10'd600; y = 10'd600; pix_color = 12'hABC;
      end
      step();
      frame_start = 1'b0;
      if (present && !at_fs) begin
         x = cx; y = cy; pix_color = c; hit_cyc = cyc;
      end else begin
         x = 10'd601; y = 10'd600; pix_color = 12'hABC;
      end
      for (int k = 0; k < 4; k++) begin
         step();
         x = 10'(700 + k); y = 10'd700; pix_color = 12'h5A5;
      end
      step();
      pix_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 50 && pick_busy === 1'b1; i++) step();
      chk(name, pick_busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      step(); step();
      rst = 1'b0;
      chk("reset_state", {pick_busy, pick_valid, pick_x, pick_y, pick_err}, 0);

      // T1: steady colour 0x290 at cursor (0x20,0x14)
      pick(10'h20, 10'h14);
      chk("t1_busy", pick_busy, 1);
      frame(10'h20, 10'h14, 12'h290, 1, 0);
      frame(10'h20, 10'h14, 12'h290, 1, 0);
      exp_q.push_back('{10'h20, 10'h14, 1'b0});
      frame(10'h20, 10'h14, 12'h290, 1, 0);
      wait_idle("t1_idle");

      // T2: disagreement restarts the match run
      pick(10'h20, 10'h14);
      frame(10'h20, 10'h14, 12'h290, 1, 0);
      frame(10'h20, 10'h14, 12'h291, 1, 0);
      chk("t2_busy_after_f2", pick_busy, 1);
      frame(10'h20, 10'h14, 12'h291, 1, 0);
      chk("t2_busy_after_f3", pick_busy, 1);
      exp_q.push_back('{10'h22, 10'h14, 1'b0});
      frame(10'h20, 10'h14, 12'h291, 1, 0);
      wait_idle("t2_idle");

      // T4: consumer stalls; outputs hold, pick_req and pixel changes ignored
      pick_ready = 1'b0;
      pick(10'h20, 10'h14);
      frame(10'h20, 10'h14, 12'h290, 1, 0);
      frame(10'h20, 10'h14, 12'h290, 1, 0);
      exp_q.push_back('{10'h20, 10'h14, 1'b0});
      frame(10'h20, 10'h14, 12'h290, 1, 0);
      pix_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         pick_req = (i == 3);
         pix_color = 12'(i * 37);
         chk("t4_hold", {pick_busy, pick_valid, pick_x, pick_y, pick_err},
             {1'b1, 1'b1, 10'h20, 10'h14, 1'b0});
      end
      pix_valid = 1'b0;
      step();
      pick_ready = 1'b1; pick_req = 1'b1;
      step();
      pick_req = 1'b0;
      chk("t4_idle_after_hs", {pick_busy, pick_valid}, 0);
      step();
      chk("t4_req_ignored", pick_busy, 0);

      // T5: reset during SAMPLE after one match
      pick(10'h20, 10'h14);
      frame(10'h20, 10'h14, 12'h290, 1, 0);
      step();
      frame_start = 1'b1; pix_valid = 1'b1; x = 10'd600; y = 10'd600;
      step();
      frame_start = 1'b0; pix_valid = 1'b0; rst = 1'b1;
      step();
      chk("t5_after_reset", {pick_busy, pick_valid, pick_x, pick_y, pick_err}, 0);
      rst = 1'b0;
      pick(10'h20, 10'h14);
      frame(10'h20, 10'h14, 12'h290, 1, 0);
      frame(10'h20, 10'h14, 12'h290, 1, 0);
      chk("t5_needs_three", pick_busy, 1);
      exp_q.push_back('{10'h20, 10'h14, 1'b0});
      frame(10'h20, 10'h14, 12'h290, 1, 0);
      wait_idle("t5_idle");

      // T3: cursor never scanned -> error after MAX_MISS misses
      pick(10'h3FF, 10'h10);
      frame(10'h3FF, 10'h10, 12'h290, 0, 0);
      frame(10'h3FF, 10'h10, 12'h290, 0, 0);
      chk("t3_busy_before_abort", pick_busy, 1);
      exp_q.push_back('{10'h0, 10'h0, 1'b1});
      frame(10'h3FF, 10'h10, 12'h290, 0, 0);
      wait_idle("t3_idle");

      // T6: hit coincides with frame_start in ARM; sx moves after the latch
      pick(10'h0, 10'h0);
      sx = 10'h55; sy = 10'h12;
      frame(10'h0, 10'h0, 12'h000, 1, 1);
      frame(10'h0, 10'h0, 12'h000, 1, 1);
      exp_q.push_back('{10'h0, 10'h0, 1'b0});
      frame(10'h0, 10'h0, 12'h000, 1, 1);
      wait_idle("t6_idle");

      repeat (3) step();
      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
